// File: rtl/bubble_pkg.sv
// Shared types and default timing constants for the bubble access timer.
package bubble_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        REP_WAIT = 2'd2,
        READ     = 2'd3
    } bubble_state_e;

    localparam int CLKS_PER_BIT = 120;
    localparam int LOOP_LEN     = 2053;
    localparam int REP_DELAY    = 16;
    localparam int PAGE_BITS    = 584;

    // True in the states where a page read is in flight.
    function automatic logic in_read(input bubble_state_e s);
        return (s == REP_WAIT) || (s == READ);
    endfunction

endpackage

// File: rtl/bubble_input_sync.sv
// Two-flop synchronizer for one asynchronous strobe, with an extra flop
// holding the previous synchronized level so edges can be detected.
module bubble_input_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus previous-level flop; preset to the inactive level.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;
    assign rise_o = ~prev_q & sync_q;

endmodule

// File: rtl/bubble_access_timer.sv
// Bubble access timer: synchronizes host strobes, tracks the minor-loop
// position and produces one bit strobe per bit cell during a page read.
module bubble_access_timer
    import bubble_pkg::*;
#(
    parameter int CLKS_PER_BIT_P = bubble_pkg::CLKS_PER_BIT,
    parameter int LOOP_LEN_P     = bubble_pkg::LOOP_LEN,
    parameter int REP_DELAY_P    = bubble_pkg::REP_DELAY,
    parameter int PAGE_BITS_P    = bubble_pkg::PAGE_BITS,
    localparam int POS_W         = $clog2(LOOP_LEN_P),
    localparam int IDX_W         = $clog2(PAGE_BITS_P)
) (
    input  logic             master_clock,
    input  logic             reset_n,
    input  logic             bubble_shift_enable,
    input  logic             replicator_enable,
    input  logic             bootloop_enable,
    output logic             bit_strobe,
    output logic [IDX_W-1:0] bit_index,
    output logic [POS_W-1:0] page_addr,
    output logic             read_active,
    output logic             bootloop_mode,
    output logic [POS_W-1:0] position,
    output logic             access_error
);

    localparam int PRE_W = (CLKS_PER_BIT_P > 1) ? $clog2(CLKS_PER_BIT_P) : 1;
    localparam int DLY_W = $clog2(REP_DELAY_P + 1);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_BIT_P - 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(LOOP_LEN_P - 1);
    localparam logic [DLY_W-1:0] DLY_MAX = DLY_W'(REP_DELAY_P - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAGE_BITS_P - 1);

    logic shift_lvl_s, shift_fall_s, shift_rise_s;
    logic rep_lvl_s,   rep_fall_s,   rep_rise_s;
    logic boot_lvl_s,  boot_fall_s,  boot_rise_s;
    logic unused_s;

    bubble_input_sync #(.RESET_VAL(1'b1)) u_sync_shift (
        .clk_i   (master_clock),
        .rst_ni  (reset_n),
        .async_i (bubble_shift_enable),
        .sync_o  (shift_lvl_s),
        .fall_o  (shift_fall_s),
        .rise_o  (shift_rise_s)
    );

    bubble_input_sync #(.RESET_VAL(1'b1)) u_sync_rep (
        .clk_i   (master_clock),
        .rst_ni  (reset_n),
        .async_i (replicator_enable),
        .sync_o  (rep_lvl_s),
        .fall_o  (rep_fall_s),
        .rise_o  (rep_rise_s)
    );

    bubble_input_sync #(.RESET_VAL(1'b1)) u_sync_boot (
        .clk_i   (master_clock),
        .rst_ni  (reset_n),
        .async_i (bootloop_enable),
        .sync_o  (boot_lvl_s),
        .fall_o  (boot_fall_s),
        .rise_o  (boot_rise_s)
    );

    // Only the shift level, replicator fall and bootloop level drive the timer.
    assign unused_s = ^{shift_fall_s, shift_rise_s, rep_lvl_s, rep_rise_s,
                        boot_fall_s, boot_rise_s};

    bubble_state_e    state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] bit_index_q, bit_index_d;
    logic [POS_W-1:0] page_addr_q, page_addr_d;
    logic             boot_mode_q, boot_mode_d;
    logic             strobe_q, strobe_d;
    logic             err_q, err_d;
    logic             active_q, active_d;
    logic             tick_s;

    // Bit-cell tick: last prescaler count while the loops are rotating.
    assign tick_s = (state_q != IDLE) && (presc_q == PRE_MAX);

    // Next-state logic for the FSM, counters and registered outputs.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        pos_d       = pos_q;
        dly_d       = dly_q;
        idx_d       = idx_q;
        bit_index_d = bit_index_q;
        page_addr_d = page_addr_q;
        boot_mode_d = boot_mode_q;
        strobe_d    = 1'b0;
        err_d       = 1'b0;

        if (state_q != IDLE) begin
            presc_d = tick_s ? {PRE_W{1'b0}} : (presc_q + PRE_W'(1));
        end else begin
            presc_d = presc_q;
        end

        if (tick_s) begin
            pos_d = (pos_q == POS_MAX) ? {POS_W{1'b0}} : (pos_q + POS_W'(1));
        end else begin
            pos_d = pos_q;
        end

        // Shift disable overrides everything else, including a replicator edge.
        if ((state_q != IDLE) && shift_lvl_s) begin
            state_d     = IDLE;
            idx_d       = {IDX_W{1'b0}};
            bit_index_d = {IDX_W{1'b0}};
            dly_d       = {DLY_W{1'b0}};
            err_d       = in_read(state_q);
        end else begin
            case (state_q)
                IDLE: begin
                    if (!shift_lvl_s) begin
                        state_d = SHIFT;
                        presc_d = {PRE_W{1'b0}};
                    end else begin
                        state_d = IDLE;
                    end
                end
                SHIFT: begin
                    if (rep_fall_s) begin
                        state_d     = REP_WAIT;
                        page_addr_d = pos_q;
                        boot_mode_d = ~boot_lvl_s;
                        dly_d       = {DLY_W{1'b0}};
                        idx_d       = {IDX_W{1'b0}};
                        bit_index_d = {IDX_W{1'b0}};
                    end else begin
                        state_d = SHIFT;
                    end
                end
                REP_WAIT: begin
                    err_d = rep_fall_s;
                    if (tick_s) begin
                        if (dly_q == DLY_MAX) begin
                            state_d = READ;
                            dly_d   = {DLY_W{1'b0}};
                        end else begin
                            dly_d = dly_q + DLY_W'(1);
                        end
                    end else begin
                        dly_d = dly_q;
                    end
                end
                READ: begin
                    err_d = rep_fall_s;
                    if (tick_s) begin
                        strobe_d    = 1'b1;
                        bit_index_d = idx_q;
                        if (idx_q == IDX_MAX) begin
                            state_d = SHIFT;
                            idx_d   = {IDX_W{1'b0}};
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        idx_d = idx_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        active_d = in_read(state_d);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge master_clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            presc_q     <= {PRE_W{1'b0}};
            pos_q       <= {POS_W{1'b0}};
            dly_q       <= {DLY_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            bit_index_q <= {IDX_W{1'b0}};
            page_addr_q <= {POS_W{1'b0}};
            boot_mode_q <= 1'b0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            pos_q       <= pos_d;
            dly_q       <= dly_d;
            idx_q       <= idx_d;
            bit_index_q <= bit_index_d;
            page_addr_q <= page_addr_d;
            boot_mode_q <= boot_mode_d;
            strobe_q    <= strobe_d;
            err_q       <= err_d;
            active_q    <= active_d;
        end
    end

    assign bit_strobe    = strobe_q;
    assign bit_index     = bit_index_q;
    assign page_addr     = page_addr_q;
    assign read_active   = active_q;
    assign bootloop_mode = boot_mode_q;
    assign position      = pos_q;
    assign access_error  = err_q;

endmodule
